// File: rtl/sequencer_ctrl.sv
// Mode/pattern controller for the step sequencer: PIANO/EDIT/PLAY FSM, 8-step note pattern, tempo register.
// Optional macro SEQ_GATE_GAP_EN adds a post-beat gate-off gap so repeated notes retrigger.
module sequencer_ctrl #(
  parameter int unsigned STEPS      = 8,
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned TEMPO_W    = 23,
  parameter int unsigned TEMPO_RST  = 4999,
  parameter int unsigned TEMPO_MIN  = 999,
  parameter int unsigned TEMPO_MAX  = 19999,
  parameter int unsigned TEMPO_STEP = 250,
  parameter int unsigned GATE_GAP   = 200
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       mode_btn,
  input  logic                       tempo_up,
  input  logic                       tempo_down,
  input  logic                       key_valid,
  input  logic [NOTE_W-1:0]          key_note,
  input  logic                       rest_btn,
  input  logic                       beat_pulse,
  output logic [1:0]                 mode,
  output logic                       sequencer_on,
  output logic [TEMPO_W-1:0]         tempo,
  output logic [$clog2(STEPS)-1:0]   step,
  output logic [NOTE_W-1:0]          note_out,
  output logic                       gate_out
);

  localparam int unsigned SW  = $clog2(STEPS);
  localparam int unsigned TW1 = TEMPO_W + 1;

  typedef enum logic [1:0] {
    PIANO = 2'b00,
    EDIT  = 2'b01,
    PLAY  = 2'b10
  } mode_t;

  mode_t              state;
  logic [STEPS-1:0]   pat_valid;
  logic [NOTE_W-1:0]  pat_note [STEPS];
  logic [TEMPO_W-1:0] tempo_nxt;
  logic [TEMPO_W:0]   tempo_dec;
  logic [TEMPO_W:0]   tempo_inc;

  // One extra bit catches the borrow so a decrement below zero saturates instead of wrapping
  always_comb begin
    tempo_dec = {1'b0, tempo} - TW1'(TEMPO_STEP);
    tempo_inc = {1'b0, tempo} + TW1'(TEMPO_STEP);
    tempo_nxt = tempo;
    if (tempo_up && !tempo_down) begin
      if (tempo_dec[TEMPO_W] || (tempo_dec < TW1'(TEMPO_MIN)))
        tempo_nxt = TEMPO_W'(TEMPO_MIN);
      else
        tempo_nxt = tempo_dec[TEMPO_W-1:0];
    end else if (tempo_down && !tempo_up) begin
      if (tempo_inc > TW1'(TEMPO_MAX))
        tempo_nxt = TEMPO_W'(TEMPO_MAX);
      else
        tempo_nxt = tempo_inc[TEMPO_W-1:0];
    end
  end

`ifdef SEQ_GATE_GAP_EN
  localparam int unsigned GW = $clog2(GATE_GAP + 1);
  logic [GW-1:0] gap_cnt;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= PIANO;
      sequencer_on <= 1'b0;
      tempo        <= TEMPO_W'(TEMPO_RST);
      step         <= '0;
      pat_valid    <= '0;
      for (int unsigned i = 0; i < STEPS; i++) pat_note[i] <= '0;
`ifdef SEQ_GATE_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      tempo <= tempo_nxt;
      if (mode_btn) begin
        case (state)
          PIANO:   begin state <= EDIT;  sequencer_on <= 1'b0; end
          EDIT:    begin state <= PLAY;  sequencer_on <= 1'b1; end
          default: begin state <= PIANO; sequencer_on <= 1'b0; end
        endcase
        if (state != PLAY) step <= '0;
`ifdef SEQ_GATE_GAP_EN
        gap_cnt <= '0;
`endif
      end else if (state == EDIT && (key_valid || rest_btn)) begin
        pat_valid[step] <= key_valid;
        pat_note[step]  <= key_valid ? key_note : '0;
        step            <= step + SW'(1);
      end else if (state == PLAY && beat_pulse) begin
        step <= step + SW'(1);
`ifdef SEQ_GATE_GAP_EN
        gap_cnt <= GW'(GATE_GAP);
`endif
      end
`ifdef SEQ_GATE_GAP_EN
      else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
`endif
    end
  end

  assign mode     = state;
  assign note_out = pat_note[step];
`ifdef SEQ_GATE_GAP_EN
  assign gate_out = (state == PLAY) && pat_valid[step] && (gap_cnt == '0);
`else
  assign gate_out = (state == PLAY) && pat_valid[step];
`endif

endmodule
